hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage core: tracks the destination register and

---
 rtl/hazard_ctrl.sv | 154 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall / forwarding sequencer for the 5-stage core.
// Shadows {valid, a3, tnew} of every in-flight instruction in E/M/W, along with
// the source registers carried by E and M. From these it derives the D-stage
// stall, every forwarding-mux select, and the mult/div busy countdown.
// Stage index: D=1, E=2, M=3, W=4. tnew is the absolute stage at which the
// result exists, so it never has to be decremented as the producer moves on.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [4:0] d_a3,
  input  logic       d_reg_write,
  input  logic [2:0] d_tuse_rs,
  input  logic [2:0] d_tuse_rt,
  input  logic [2:0] d_tnew,
  input  logic       d_is_md,
  input  logic       e_md_start,
  input  logic       e_md_is_div,
  output logic       stall,
  output logic [1:0] fwd_d_rs,
  output logic [1:0] fwd_d_rt,
  output logic [1:0] fwd_e_rs,
  output logic [1:0] fwd_e_rt,
  output logic       fwd_m_rt,
  output logic       md_busy
);

  localparam int NUM_OPS = 2;            // operand 0 = rs, operand 1 = rt
  localparam int STAGES  = 2;            // vld_pipe[0]=E, [1]=M, [2]=W
  localparam int MD_MAX  = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW      = $clog2(MD_MAX + 1);

  localparam logic [2:0] TUSE_NONE = 3'd3;
  localparam logic [3:0] STG_E     = 4'd2;
  localparam logic [3:0] STG_M     = 4'd3;
  localparam logic [3:0] STG_W     = 4'd4;

  typedef struct packed {
    logic [4:0] a3;
    logic [2:0] tnew;
  } dst_t;

  // Pipeline shadow state
  logic [STAGES:0]         vld_pipe;
  dst_t                    e_dst, m_dst, w_dst;
  logic [NUM_OPS-1:0][4:0] e_src;
  logic [4:0]              m_rt;
  logic [CW-1:0]           md_cnt;

  // D-stage operands gathered into arrays so both are handled by one loop
  logic [NUM_OPS-1:0][4:0] d_src;
  logic [NUM_OPS-1:0][2:0] d_tuse;
  assign d_src  = {d_rt, d_rs};
  assign d_tuse = {d_tuse_rt, d_tuse_rs};

  logic [NUM_OPS-1:0]      hz;
  logic [NUM_OPS-1:0][1:0] fwd_d;
  logic [NUM_OPS-1:0][1:0] fwd_e;
  logic                    md_hz;
  logic                    stall_raw;
  logic                    e_vld_nxt;

  // Per-operand hazard detection and forward select
  for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_op
    logic       used;
    logic [3:0] tuse4;
    logic       d_hit_e, d_hit_m, d_hit_w;
    logic       e_hit_m, e_hit_w;

    assign used  = d_tuse[gi] != TUSE_NONE;
    assign tuse4 = {1'b0, d_tuse[gi]};

    assign d_hit_e = vld_pipe[0] && e_dst.a3 == d_src[gi] && d_src[gi] != 5'd0;
    assign d_hit_m = vld_pipe[1] && m_dst.a3 == d_src[gi] && d_src[gi] != 5'd0;
    assign d_hit_w = vld_pipe[2] && w_dst.a3 == d_src[gi] && d_src[gi] != 5'd0;

    // Stall when the producer cannot have its result by the time D's
    // instruction actually consumes the operand (producer will be at p+tuse).
    assign hz[gi] = used &&
      ((d_hit_e && {1'b0, e_dst.tnew} > STG_E + tuse4) ||
       (d_hit_m && {1'b0, m_dst.tnew} > STG_M + tuse4) ||
       (d_hit_w && {1'b0, w_dst.tnew} > STG_W + tuse4));

    // Nearest match wins; an unready nearest match selects the register file
    // (that case is covered by stall) rather than an older, stale producer.
    // W needs no select: the GRF writes through to D.
    assign fwd_d[gi] = d_hit_e ? (({1'b0, e_dst.tnew} <= STG_E) ? 2'd1 : 2'd0) :
                       d_hit_m ? (({1'b0, m_dst.tnew} <= STG_M) ? 2'd2 : 2'd0) :
                                 2'd0;

    assign e_hit_m = vld_pipe[1] && m_dst.a3 == e_src[gi] && e_src[gi] != 5'd0;
    assign e_hit_w = vld_pipe[2] && w_dst.a3 == e_src[gi] && e_src[gi] != 5'd0;

    assign fwd_e[gi] = e_hit_m ? (({1'b0, m_dst.tnew} <= STG_M) ? 2'd1 : 2'd0) :
                       e_hit_w ? (({1'b0, w_dst.tnew} <= STG_W) ? 2'd2 : 2'd0) :
                                 2'd0;
  end

  assign fwd_d_rs = fwd_d[0];
  assign fwd_d_rt = fwd_d[1];
  assign fwd_e_rs = fwd_e[0];
  assign fwd_e_rt = fwd_e[1];

  // DM store data: only W can still be ahead of an instruction sitting in M
  assign fwd_m_rt = vld_pipe[2] && w_dst.a3 == m_rt && m_rt != 5'd0 &&
                    {1'b0, w_dst.tnew} <= STG_W;

  assign md_busy = md_cnt != '0;
  // The start cycle itself must already block a dependent mult/div op in D
  assign md_hz   = d_is_md && (md_busy || e_md_start);

  assign stall_raw = (|hz) | md_hz;
  // Gated by reset so an asserted reset drops a pending stall immediately,
  // even while D-stage / start inputs would otherwise still demand one.
  assign stall     = reset_n && stall_raw;

  // Writes to $0 or non-writing instructions never count as producers
  assign e_vld_nxt = !stall_raw && d_reg_write && d_a3 != 5'd0;

  // Destination/source shadow pipeline; stall injects a bubble into E
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      e_dst    <= '0;
      m_dst    <= '0;
      w_dst    <= '0;
      e_src    <= '0;
      m_rt     <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], e_vld_nxt};
      e_dst    <= stall_raw ? dst_t'('0) : dst_t'{a3: d_a3, tnew: d_tnew};
      m_dst    <= e_dst;
      w_dst    <= m_dst;
      e_src    <= stall_raw ? '0 : d_src;
      m_rt     <= e_src[1];
    end
  end

  // Mult/div countdown; a start seen while already busy is ignored
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      md_cnt <= '0;
    end else if (e_md_start && !md_busy) begin
      md_cnt <= e_md_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end else if (md_busy) begin
      md_cnt <= md_cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed instruction sequences with hand-computed expected
// outputs pushed to a scoreboard queue; a monitor pops and compares each cycle.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] d_rs, d_rt, d_a3;
  logic       d_reg_write;
  logic [2:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_is_md, e_md_start, e_md_is_div;
  logic       stall, fwd_m_rt, md_busy;
  logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;

  always #5 clk = ~clk;

  hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n),
    .d_rs(d_rs), .d_rt(d_rt), .d_a3(d_a3), .d_reg_write(d_reg_write),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_tnew(d_tnew),
    .d_is_md(d_is_md), .e_md_start(e_md_start), .e_md_is_div(e_md_is_div),
    .stall(stall), .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
    .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt), .fwd_m_rt(fwd_m_rt),
    .md_busy(md_busy)
  );

  typedef struct packed {
    logic [10:0] val;
    logic [10:0] care;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  localparam logic [10:0] ALL     = 11'h7FF;
  localparam logic [10:0] NO_FMRT = 11'h7FD;
  localparam logic [10:0] ZERO    = 11'h000;

  // {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, md_busy}
  function automatic logic [10:0] ev(input logic st, input logic [1:0] fdrs,
                                     input logic [1:0] fdrt, input logic [1:0] fers,
                                     input logic [1:0] fert, input logic fmrt,
                                     input logic busy);
    return {st, fdrs, fdrt, fers, fert, fmrt, busy};
  endfunction

  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] a3,
                       input logic rw, input logic [2:0] tr, input logic [2:0] tt,
                       input logic [2:0] tn, input logic md);
    d_rs = rs; d_rt = rt; d_a3 = a3; d_reg_write = rw;
    d_tuse_rs = tr; d_tuse_rt = tt; d_tnew = tn; d_is_md = md;
  endtask

  task automatic i_nop();                      set_d(5'd0, 5'd0, 5'd0, 1'b0, 3'd3, 3'd3, 3'd0, 1'b0); endtask
  task automatic i_lw(input logic [4:0] a3);   set_d(5'd0, a3, a3, 1'b1, 3'd1, 3'd3, 3'd4, 1'b0); endtask
  task automatic i_add(input logic [4:0] a3, input logic [4:0] rs, input logic [4:0] rt);
    set_d(rs, rt, a3, 1'b1, 3'd1, 3'd1, 3'd3, 1'b0);
  endtask
  task automatic i_beq(input logic [4:0] rs, input logic [4:0] rt);
    set_d(rs, rt, 5'd0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
  endtask
  task automatic i_sw(input logic [4:0] rt);   set_d(5'd0, rt, 5'd0, 1'b0, 3'd1, 3'd2, 3'd0, 1'b0); endtask
  task automatic i_jal();                      set_d(5'd0, 5'd0, 5'd31, 1'b1, 3'd3, 3'd3, 3'd0, 1'b0); endtask
  task automatic i_jr(input logic [4:0] rs);   set_d(rs, 5'd0, 5'd0, 1'b0, 3'd0, 3'd3, 3'd0, 1'b0); endtask
  task automatic i_wr(input logic [4:0] a3, input logic [2:0] tn, input logic rw);
    set_d(5'd0, 5'd0, a3, rw, 3'd3, 3'd3, tn, 1'b0);
  endtask

  // Queue the expectation for the current cycle, then advance one clock
  task automatic step(input string nm, input logic [10:0] v, input logic [10:0] c);
    exp_t e;
    e.val = v; e.care = c;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk); #1;
  endtask

  task automatic flush(input int n);
    i_nop();
    for (int i = 0; i < n; i++) step("flush", ZERO, ALL);
  endtask

  // Monitor: outputs are combinational, so every cycle presents a response
  initial begin : monitor
    exp_t        me;
    string       mn;
    logic [10:0] got;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        me  = exp_q.pop_front();
        mn  = name_q.pop_front();
        got = {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, md_busy};
        checks++;
        if (((got ^ me.val) & me.care) !== 11'd0) begin
          errors++;
          $display("FAIL %s: got=%b expected=%b care=%b", mn, got, me.val, me.care);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    reset_n = 1'b0;
    i_nop();
    d_is_md = 1'b1; e_md_start = 1'b1; e_md_is_div = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    step("rst_hold", ZERO, ALL);
    reset_n = 1'b1; i_nop(); e_md_start = 1'b0; e_md_is_div = 1'b0;
    step("idle", ZERO, ALL);

    // lw $1 ; add $2,$1,$1 : one stall, then both E operands from W
    i_lw(5'd1);                   step("lw_add_issue", ZERO, ALL);
    i_add(5'd2, 5'd1, 5'd1);      step("lw_add_stall", ev(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0), ALL);
                                  step("lw_add_go",    ZERO, ALL);
    i_nop();                      step("lw_add_fwd_w", ev(1'b0, 2'd0, 2'd0, 2'd2, 2'd2, 1'b0, 1'b0), ALL);
    flush(3);

    // lw $1 ; beq $1,$0 : two stalls, then read via GRF
    i_lw(5'd1);                   step("lw_beq_issue", ZERO, ALL);
    i_beq(5'd1, 5'd0);            step("lw_beq_stall1", ev(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0), ALL);
                                  step("lw_beq_stall2", ev(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0), ALL);
                                  step("lw_beq_go",     ZERO, ALL);
    flush(3);

    // add $3 ; sw $3 : no stall, store data forwarded from M into E
    i_add(5'd3, 5'd0, 5'd0);      step("add_sw_issue", ZERO, ALL);
    i_sw(5'd3);                   step("add_sw_nostall", ZERO, ALL);
    i_nop();                      step("add_sw_fwd_e",   ev(1'b0, 2'd0, 2'd0, 2'd0, 2'd1, 1'b0, 1'b0), ALL);
                                  step("add_sw_m",       ZERO, NO_FMRT);
    flush(3);

    // lw $5 ; sw $5 : no stall, store data forwarded from W into M
    i_lw(5'd5);                   step("lw_sw_issue", ZERO, ALL);
    i_sw(5'd5);                   step("lw_sw_nostall", ZERO, ALL);
    i_nop();                      step("lw_sw_e",       ZERO, ALL);
                                  step("lw_sw_fwd_m",   ev(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0), ALL);
    flush(3);

    // jal ; jr $31 : link value ready in E (tnew=0)
    i_jal();                      step("jal_issue", ZERO, ALL);
    i_jr(5'd31);                  step("jr_fwd_d_e", ev(1'b0, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0), ALL);
    i_nop();                      step("jr_fwd_e_m", ev(1'b0, 2'd0, 2'd0, 2'd1, 2'd0, 1'b0, 1'b0), ALL);
    flush(3);

    // Two producers of $9: the nearer one must win at every stage
    i_add(5'd9, 5'd0, 5'd0);      step("pri_p1", ZERO, ALL);
    i_wr(5'd9, 3'd0, 1'b1);       step("pri_p2", ZERO, ALL);
    i_beq(5'd9, 5'd9);            step("pri_d_nearest", ev(1'b0, 2'd1, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0), ALL);
    i_nop();                      step("pri_e_nearest", ev(1'b0, 2'd0, 2'd0, 2'd1, 2'd1, 1'b0, 1'b0), ALL);
                                  step("pri_m_from_w",  ev(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0), ALL);
    flush(3);

    // Non-writing producer and writes to $0 never stall or forward
    i_wr(5'd10, 3'd4, 1'b0);      step("nowr_issue", ZERO, ALL);
    i_beq(5'd10, 5'd10);          step("nowr_beq",   ZERO, ALL);
    i_nop();                      step("nowr_e",     ZERO, ALL);
    i_wr(5'd0, 3'd4, 1'b1);       step("r0_issue",   ZERO, ALL);
    i_add(5'd2, 5'd0, 5'd0);      step("r0_use",     ZERO, ALL);
    flush(3);

    // div ; mflo : start cycle + 10 busy cycles of stall
    set_d(5'd4, 5'd5, 5'd0, 1'b0, 3'd1, 3'd1, 3'd0, 1'b1);
    step("div_issue", ZERO, ALL);
    set_d(5'd0, 5'd0, 5'd6, 1'b1, 3'd3, 3'd3, 3'd3, 1'b1);
    e_md_start = 1'b1; e_md_is_div = 1'b1;
    step("div_start_stall", ev(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0), ALL);
    e_md_start = 1'b0; e_md_is_div = 1'b0;
    for (int i = 0; i < 10; i++)
      step("div_busy_stall", ev(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1), ALL);
    step("div_done", ZERO, ALL);
    flush(3);

    // mult busy for 5 cycles; a start seen while busy is ignored
    i_nop();
    e_md_start = 1'b1; e_md_is_div = 1'b0;
    step("mult_start", ZERO, ALL);
    e_md_start = 1'b0;
    for (int i = 0; i < 2; i++)
      step("mult_busy", ev(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1), ALL);
    e_md_start = 1'b1; e_md_is_div = 1'b1;
    step("start_in_busy", ev(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1), ALL);
    e_md_start = 1'b0; e_md_is_div = 1'b0;
    for (int i = 0; i < 2; i++)
      step("mult_busy_tail", ev(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1), ALL);
    step("mult_done", ZERO, ALL);

    // Reset asserted mid-stall drops stall at once and clears the shadows
    i_lw(5'd1);                   step("rst_lw_issue", ZERO, ALL);
    i_beq(5'd1, 5'd0);            step("rst_pre_stall", ev(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0), ALL);
    reset_n = 1'b0;               step("rst_mid_stall", ZERO, ALL);
    reset_n = 1'b1;               step("rst_released", ZERO, ALL);
    flush(2);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
